if_stage_pipelined: RTL and testbench

- Parametrised instruction-fetch stage for the MIPS pipeline.
- Holds the PC register, a synchronous-read instruction memory, the IF/ID output register and a run-control FSM (LOAD/RUN/HALT).
- Adds what a bare fetch stage lacks:
  - stall and flush from the hazard unit;
  - branch redirect with optional squash;
  - a program-load port;
  - HALT detection that freezes fetch.
- Feeds the decode stage; driven by the hazard/branch logic and the debug unit.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_stage_pipelined_imem.sv | 31 +++
 rtl/if_stage_pipelined.sv | 137 +++++++++++++
 tb/tb_if_stage_pipelined.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: run-control states,
// the NOP word and the position of the opcode field used for HALT detection.
package if_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          OPC_HI   = 31;
    localparam int          OPC_LO   = 26;

endpackage

// File: rtl/if_stage_pipelined_imem.sv
// Single-clock instruction RAM: one write port, one read port with a read
// enable and a registered output.
module imem_sync #(
    parameter int    DEPTH     = 2048,
    parameter int    WIDTH     = 32,
    parameter int    AW        = $clog2(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The read register doubles as the instruction field of IF/ID, so a
    // gated read enable is what holds the instruction during a stall.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/if_stage_pipelined.sv
// MIPS instruction-fetch stage: PC register, synchronous instruction memory,
// IF/ID register and a LOAD/RUN/HALT run-control FSM.
module if_stage_pipelined
    import if_pkg::*;
#(
    parameter int          LEN              = 32,
    parameter int          MEM_DEPTH        = 2048,
    parameter int          PC_STEP          = 1,
    parameter int          RESET_PC         = 0,
    parameter int          SQUASH_ON_BRANCH = 1,
    parameter logic [5:0]  HALT_OPCODE      = 6'b111111,
    parameter string       INIT_FILE        = ""
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic                         i_pc_src,
    input  logic [LEN-1:0]               i_branch_dir,
    input  logic                         i_start,
    input  logic                         i_restart,
    input  logic                         i_load_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_load_addr,
    input  logic [LEN-1:0]               i_load_data,
    output logic [LEN-1:0]               o_contador_programa,
    output logic [LEN-1:0]               o_pc_plus,
    output logic [LEN-1:0]               o_instruccion,
    output logic                         o_valid,
    output logic                         o_halted,
    output logic [1:0]                   o_state
);

    localparam int             AW     = $clog2(MEM_DEPTH);
    localparam logic [LEN-1:0] RST_PC = LEN'(RESET_PC);
    localparam logic [LEN-1:0] STEP   = LEN'(PC_STEP);

    state_t         state_reg, state_next;
    logic [LEN-1:0] pc_reg, pc_next;
    logic [LEN-1:0] pc_plus_reg;
    logic           valid_reg, valid_next;
    logic [LEN-1:0] pc_inc;
    logic [LEN-1:0] mem_rdata;
    logic           mem_re, mem_we, halt_seen, in_run;

    assign in_run    = (state_reg == ST_RUN);
    assign pc_inc    = pc_reg + STEP;
    assign mem_re    = in_run && !i_stall;
    assign mem_we    = (state_reg == ST_LOAD) && i_load_we;
    assign halt_seen = valid_reg && (mem_rdata[OPC_HI:OPC_LO] == HALT_OPCODE);

    imem_sync #(
        .DEPTH     (MEM_DEPTH),
        .WIDTH     (LEN),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_imem (
        .clk   (i_clk),
        .we    (mem_we),
        .waddr (i_load_addr),
        .wdata (i_load_data),
        .re    (mem_re),
        .raddr (pc_reg[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        unique case (state_reg)
            ST_LOAD: begin
                pc_next    = RST_PC;
                valid_next = 1'b0;
                if (i_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_seen && !i_flush) begin
                    state_next = ST_HALT;
                end
                if (!i_stall && !halt_seen) begin
                    pc_next = i_pc_src ? i_branch_dir : pc_inc;
                end
                // The word fetched in a redirect cycle is on the wrong path
                // unless the pipeline treats it as a delay slot.
                if (i_flush) begin
                    valid_next = 1'b0;
                end else if (i_stall) begin
                    valid_next = valid_reg;
                end else if (halt_seen) begin
                    valid_next = 1'b0;
                end else if ((SQUASH_ON_BRANCH != 0) && i_pc_src) begin
                    valid_next = 1'b0;
                end else begin
                    valid_next = 1'b1;
                end
            end
            ST_HALT: begin
                valid_next = 1'b0;
                if (i_restart) begin
                    state_next = ST_LOAD;
                    pc_next    = RST_PC;
                end
            end
            default: begin
                state_next = ST_LOAD;
                pc_next    = RST_PC;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_LOAD;
            pc_reg      <= RST_PC;
            valid_reg   <= 1'b0;
            pc_plus_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
            if (mem_re) begin
                pc_plus_reg <= pc_inc;
            end
        end
    end

    assign o_contador_programa = pc_reg;
    assign o_pc_plus           = pc_plus_reg;
    assign o_instruccion       = valid_reg ? mem_rdata : LEN'(NOP_WORD);
    assign o_valid             = valid_reg;
    assign o_halted            = (state_reg == ST_HALT);
    assign o_state             = state_reg;

endmodule

// File: tb/tb_if_stage_pipelined.sv
// Bench for if_stage_pipelined: three instances (squash, delay-slot, 4-word
// memory) share stimulus and are checked each cycle against a program model.
module tb_if_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst, stall, flush, pc_src, start, restart, ld_we;
    logic [31:0] br_dir, ld_data;
    logic [10:0] ld_addr;

    logic [31:0] pc_o [3];
    logic [31:0] pp_o [3];
    logic [31:0] ins_o[3];
    logic        val_o[3];
    logic        hlt_o[3];
    logic [1:0]  st_o [3];

    int n_cmp = 0;
    int n_bad = 0;
    int n_tick = 0;

    // reference model: per instance program memory and IF/ID contents
    int unsigned depth_m[3] = '{2048, 2048, 4};
    bit          sq_m[3]    = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mem_m[3][2048];
    int          st_m[3];
    logic [31:0] pc_m[3], word_m[3], pp_m[3];
    bit          val_m[3];

    always #5 clk = ~clk;

    if_stage_pipelined #(.SQUASH_ON_BRANCH(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_pc_src(pc_src),
        .i_branch_dir(br_dir), .i_start(start), .i_restart(restart), .i_load_we(ld_we),
        .i_load_addr(ld_addr), .i_load_data(ld_data), .o_contador_programa(pc_o[0]),
        .o_pc_plus(pp_o[0]), .o_instruccion(ins_o[0]), .o_valid(val_o[0]),
        .o_halted(hlt_o[0]), .o_state(st_o[0]));

    if_stage_pipelined #(.SQUASH_ON_BRANCH(0)) u_dut_ns (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_pc_src(pc_src),
        .i_branch_dir(br_dir), .i_start(start), .i_restart(restart), .i_load_we(ld_we),
        .i_load_addr(ld_addr), .i_load_data(ld_data), .o_contador_programa(pc_o[1]),
        .o_pc_plus(pp_o[1]), .o_instruccion(ins_o[1]), .o_valid(val_o[1]),
        .o_halted(hlt_o[1]), .o_state(st_o[1]));

    if_stage_pipelined #(.MEM_DEPTH(4)) u_dut_w (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_pc_src(pc_src),
        .i_branch_dir(br_dir), .i_start(start), .i_restart(restart), .i_load_we(ld_we),
        .i_load_addr(ld_addr[1:0]), .i_load_data(ld_data), .o_contador_programa(pc_o[2]),
        .o_pc_plus(pp_o[2]), .o_instruccion(ins_o[2]), .o_valid(val_o[2]),
        .o_halted(hlt_o[2]), .o_state(st_o[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            st_m[k] = 0; pc_m[k] = 0; word_m[k] = 0; pp_m[k] = 0; val_m[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit          halt, n_val;
        logic [31:0] fetched;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            halt    = val_m[k] && (word_m[k][31:26] == 6'h3F);
            fetched = mem_m[k][pc_m[k] % depth_m[k]];
            case (st_m[k])
                0: begin
                    if (ld_we) mem_m[k][ld_addr % depth_m[k]] = ld_data;
                    if (start) st_m[k] = 1;
                    pc_m[k] = 0; val_m[k] = 1'b0;
                end
                1: begin
                    n_val = val_m[k];
                    if (flush) n_val = 1'b0;
                    else if (!stall) n_val = !halt && !(pc_src && sq_m[k]);
                    if (!stall) begin
                        word_m[k] = fetched;
                        pp_m[k]   = pc_m[k] + 1;
                        if (!halt) pc_m[k] = pc_src ? br_dir : pc_m[k] + 1;
                    end
                    val_m[k] = n_val;
                    if (halt && !flush) st_m[k] = 2;
                end
                default: begin
                    val_m[k] = 1'b0;
                    if (restart) begin st_m[k] = 0; pc_m[k] = 0; end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pc[%0d]", k), pc_o[k], pc_m[k]);
            chk($sformatf("valid[%0d]", k), 32'(val_o[k]), 32'(val_m[k]));
            chk($sformatf("instr[%0d]", k), ins_o[k], val_m[k] ? word_m[k] : 32'h0);
            if (val_m[k]) chk($sformatf("pc_plus[%0d]", k), pp_o[k], pp_m[k]);
            chk($sformatf("halted[%0d]", k), 32'(hlt_o[k]), 32'(st_m[k] == 2));
            chk($sformatf("state[%0d]", k), 32'(st_o[k]), 32'(st_m[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        n_tick++;
        $display("tick %0d: st=%0d pc=%h instr=%h valid=%0b pc_plus=%h", n_tick,
                 st_o[0], pc_o[0], ins_o[0], val_o[0], pp_o[0]);
        compare_all();
    endtask

    task automatic areset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    task automatic clear_in();
        stall = 0; flush = 0; pc_src = 0; start = 0; restart = 0; ld_we = 0;
        br_dir = 0; ld_addr = 0; ld_data = 0;
    endtask

    task automatic load_word(input logic [10:0] a, input logic [31:0] d);
        ld_we = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = ($urandom_range(0, 5) == 0) ? 6'h3F : 6'h00;
        return w;
    endfunction

    task automatic chk_main(input string tag, input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, ".instr"}, ins_o[0], ins);
        chk({tag, ".pc"}, pc_o[0], pc);
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        model_reset();
        #3;
        chk("rst.pc", pc_o[0], 32'd0);
        chk("rst.instr", ins_o[0], 32'd0);
        chk("rst.pc_plus", pp_o[0], 32'd0);
        chk("rst.valid", 32'(val_o[0]), 32'd0);
        chk("rst.halted", 32'(hlt_o[0]), 32'd0);
        chk("rst.state", 32'(st_o[0]), 32'd0);
        rst = 1'b0;

        for (int a = 0; a < 128; a++) load_word(11'(a), $urandom & 32'h03FF_FFFF);
        load_word(11'd10, 32'hAA);
        load_word(11'd0, 32'h11);
        load_word(11'd1, 32'h22);
        load_word(11'd2, 32'h33);
        load_word(11'd3, 32'hFC00_0000);

        // straight-line program ending in HALT
        start = 1'b1; tick(); start = 1'b0;
        tick(); chk_main("seq0", 32'h11, 32'd1); chk("seq0.pp", pp_o[0], 32'd1);
        tick(); chk_main("seq1", 32'h22, 32'd2); chk("seq1.pp", pp_o[0], 32'd2);
        tick(); chk_main("seq2", 32'h33, 32'd3); chk("seq2.pp", pp_o[0], 32'd3);
        tick(); chk_main("seq3", 32'hFC00_0000, 32'd4); chk("seq3.pp", pp_o[0], 32'd4);
        tick(); chk("halt.halted", 32'(hlt_o[0]), 32'd1); chk_main("halt", 32'h0, 32'd4);
        tick(); chk_main("halt_hold", 32'h0, 32'd4);

        // three-cycle stall with 0x22 in IF/ID
        restart = 1'b1; tick(); restart = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); chk_main("stall", 32'h22, 32'd2); end
        stall = 1'b0;
        tick(); chk_main("post_stall", 32'h33, 32'd3);
        tick(); tick();

        // redirect from PC=2 to 10
        restart = 1'b1; tick(); restart = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        pc_src = 1'b1; br_dir = 32'd10;
        tick(); chk_main("squash", 32'h0, 32'd10); chk("slot.instr", ins_o[1], 32'h33);
        pc_src = 1'b0;
        tick(); chk("target.instr", ins_o[0], 32'hAA); chk("target.pp", pp_o[0], 32'd11);
        chk("slot_target.instr", ins_o[1], 32'hAA);
        tick(); tick();

        // asynchronous reset mid-run; memory must survive
        rst = 1'b1;
        #2;
        chk("arst.pc", pc_o[0], 32'd0);
        chk("arst.instr", ins_o[0], 32'd0);
        chk("arst.valid", 32'(val_o[0]), 32'd0);
        chk("arst.state", 32'(st_o[0]), 32'd0);
        model_reset();
        compare_all();
        rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick(); chk_main("rerun", 32'h11, 32'd1);
        tick();

        // flush together with stall, then flush over a HALT
        flush = 1'b1; stall = 1'b1;
        tick(); chk_main("flush_stall", 32'h0, 32'd2);
        flush = 1'b0; stall = 1'b0;
        tick(); chk_main("after_flush", 32'h33, 32'd3);
        tick(); chk_main("halt_in_ifid", 32'hFC00_0000, 32'd4);
        flush = 1'b1;
        tick(); chk("flushed_halt.halted", 32'(hlt_o[0]), 32'd0);
        flush = 1'b0;
        tick(); chk("resume.valid", 32'(val_o[0]), 32'd1); chk("resume.pc", pc_o[0], 32'd5);
        areset();

        // four-word memory wraps while o_pc_plus keeps counting
        for (int a = 0; a < 4; a++) load_word(11'(a), 32'(a + 1));
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wrap.instr", ins_o[2], 32'((i % 4) + 1));
            chk("wrap.pp", pp_o[2], 32'(i + 1));
        end
        areset();

        // randomized segments: load, run with stall/flush/redirect/restart
        for (int s = 0; s < 30; s++) begin
            for (int w = 0; w < 6; w++) load_word(11'($urandom_range(0, 63)), rand_word());
            start = 1'b1; tick(); start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                stall   = ($urandom_range(0, 3) == 0);
                flush   = ($urandom_range(0, 9) == 0);
                pc_src  = ($urandom_range(0, 6) == 0);
                br_dir  = 32'($urandom_range(0, 63));
                restart = ($urandom_range(0, 7) == 0);
                start   = ($urandom_range(0, 7) == 0);
                ld_we   = ($urandom_range(0, 3) == 0);
                ld_addr = 11'($urandom_range(0, 63));
                ld_data = rand_word();
                tick();
            end
            clear_in();
            areset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
